// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Every output is a register; the winner scan is the only combinational path.
module rr_arbiter8 #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] CntMax = 8'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state;
    logic [2:0] ptr;
    logic [7:0] cnt;

    logic [2:0] winner;
    logic       found;
    logic [2:0] scan_idx;
    logic       release_now;
    logic       expire_now;

    // Scan starts just past the last winner; ptr itself is checked last.
    always_comb begin
        winner   = 3'd0;
        found    = 1'b0;
        scan_idx = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = ptr + 3'(i);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        release_now = rel || !req[grant_idx] || !en;
        expire_now  = (cnt == CntMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            ptr         <= 3'd7;
            cnt         <= 8'd0;
            grant       <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (en && found) begin
                        grant       <= 8'd1 << winner;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        cnt         <= 8'd0;
                        state       <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_now || expire_now) begin
                        grant       <= 8'd0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx;
                        timeout     <= expire_now && !release_now;
                        state       <= StIdle;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one 8-input priority-encode/display path between eight requesters. Each cycle the block picks one pending requester, holds a registered grant until that requester releases or a hold timeout expires, and then rotates priority past the last winner. The grant index (3-bit) feeds the board's LED/seven-segment display path, so the display shows which requester owns the shared resource.

## Interface
- HOLD_CYCLES, default 4, maximum cycles one grant may last (legal range 1..255).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable.
  - In IDLE, en=0 blocks new grants.
  - In GRANT, en=0 forces release at the next edge.
- req  input  8  per-requester request levels. Bit i = requester i.
- rel  input  1  release strobe from the current owner. Sampled only in GRANT.
- grant  output  8  one-hot grant, registered.
- grant_idx  output  3  binary index of the owner, registered. Holds the last value when grant_valid=0.
- grant_valid  output  1  high while any grant is active (equal to |grant).
- timeout  output  1  one-cycle pulse on the cycle after a grant ended by timeout.

## Operation
- State: 1-bit FSM {IDLE, GRANT}.
  - 3-bit rotate pointer ptr = index of the last winner.
  - 8-bit hold counter cnt.
- Reset values:
  - state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - cnt=0, ptr=7, so the first search starts at requester 0.
- Winner selection (combinational):
  - Scan req starting at (ptr+1) mod 8, increasing, wrapping 7→0.
  - The first set bit wins. The scan includes ptr itself, as the last position.
  - Index arithmetic is 3-bit, so wrap is natural.
- IDLE:
  - If en=1 and req≠0: load grant=onehot(winner), grant_idx=winner, cnt=0, state→GRANT.
  - Otherwise stay in IDLE with grant=0.
- GRANT. Exit conditions are evaluated each cycle:
  - release: rel=1, or req[grant_idx]=0, or en=0.
  - expire: cnt==HOLD_CYCLES-1.
- On release or expire:
  - grant→0, grant_valid→0, ptr←grant_idx, state→IDLE.
  - timeout←1 only if expire and not release. Release takes priority when both occur.
- Otherwise cnt←cnt+1 and the grant holds.
- timeout is cleared on every edge on which it is not being set.
- cnt never exceeds HOLD_CYCLES-1. HOLD_CYCLES=1 gives single-cycle grants.
- Requests arriving mid-grant do not preempt the current owner.
- Requests withdrawn while in IDLE simply drop out of the next scan.

## Timing
- Grant latency: req sampled at edge k in IDLE gives grant visible after edge k, i.e. one cycle after the request is present.
- Grant duration:
  - Without release: exactly HOLD_CYCLES cycles.
  - With rel high on the m-th grant cycle (m ≤ HOLD_CYCLES): m cycles.
- Handover: grant drops for exactly one cycle (the IDLE arbitration cycle) between consecutive owners. Minimum period per grant is duration+1.
- timeout is asserted in that same IDLE cycle.
- rst during GRANT: outputs return to reset values after that edge. ptr returns to 7; the rotation history is lost.
- Outputs depend on no input combinationally. All outputs are registers.

## Test plan
- Reset and first winner:
  - Stimulus: rst 2 cycles, then req=8'hFF, en=1, rel=0, HOLD_CYCLES=4.
  - Expected: grant=8'h01, grant_idx=0 one cycle later, for 4 cycles. Then timeout=1 with grant=0 for 1 cycle. Then grant=8'h02.
- Rotation/wrap:
  - Stimulus: req=8'b1000_0001 held with rel pulsed on each first grant cycle.
  - Expected: grant_idx sequence 0,7,0,7…, each grant 1 cycle wide with 1-cycle gaps. timeout never asserts.
- Release vs timeout collision:
  - Stimulus: HOLD_CYCLES=4, rel=1 on the 4th grant cycle.
  - Expected: grant ends, timeout stays 0, ptr advances.
- Requester drop and enable:
  - Stimulus 1: owner 3 deasserts req[3] mid-grant. Expected: grant ends next edge.
  - Stimulus 2: en=0 in IDLE with req=8'h10. Expected: grant stays 0 until en=1, then grant=8'h10 one cycle later.
- Mid-grant reset:
  - Stimulus: grant on index 5, rst pulsed 1 cycle.
  - Expected: all outputs 0 next cycle. With req=8'hFF, the next grant is index 0 (ptr reset), not 6.
- HOLD_CYCLES=1:
  - Stimulus: req=8'h0F continuous.
  - Expected: indices 0,1,2,3,0… Each grant is 1 cycle, and timeout pulses after every grant.
